mem_port_arbiter: RTL

- Shares one single-outstanding memory port between instruction fetch (read-only) and the MEM stage (read/write with byte strobes).
- Arbitrates between the two requesters, latches the granted request and drives the shared port.
- Tracks the address and data handshakes and routes the response back to the winning requester.
- Data side has priority; a starvation counter guarantees periodic instruction grants.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-outstanding memory port between instruction fetch and
// the MEM stage; data side wins unless fetch has been starved STARVE_LIM times.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_n;
    logic               owner, owner_n;
    logic [CNT_W-1:0]   starve_cnt, starve_cnt_n;
    logic               m_req_n, m_wr_n;
    logic [3:0]         m_wstrb_n;
    logic [31:0]        m_addr_n, m_wdata_n;
    logic               arb;
    logic               starved;
    logic               accept;
    logic               complete;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIM));

    // Handshakes are combinational so the requester sees them in the port's cycle.
    assign accept    = (state == REQ) && m_addr_ok;
    assign complete  = ((state == RESP) && m_data_ok) || (accept && m_data_ok);

    assign i_addr_ok = accept   && (owner == OWN_INST);
    assign d_addr_ok = accept   && (owner == OWN_DATA);
    assign i_data_ok = complete && (owner == OWN_INST);
    assign d_data_ok = complete && (owner == OWN_DATA);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;
    assign busy      = (state != IDLE);

    // Next-state, arbitration and port-register update.
    always_comb begin
        state_n      = state;
        owner_n      = owner;
        starve_cnt_n = starve_cnt;
        m_req_n      = m_req;
        m_wr_n       = m_wr;
        m_wstrb_n    = m_wstrb;
        m_addr_n     = m_addr;
        m_wdata_n    = m_wdata;
        arb          = 1'b0;

        case (state)
            IDLE: arb = 1'b1;
            REQ: begin
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        arb = 1'b1;
                    end else begin
                        m_req_n = 1'b0;
                        state_n = RESP;
                    end
                end
            end
            RESP: begin
                if (m_data_ok) begin
                    arb = 1'b1;
                end
            end
            default: begin
                m_req_n = 1'b0;
                state_n = IDLE;
            end
        endcase

        // Re-arbitration happens on the completion cycle, so no idle bubble.
        if (arb) begin
            if (i_req && (starved || !d_req)) begin
                state_n      = REQ;
                owner_n      = OWN_INST;
                starve_cnt_n = '0;
                m_req_n      = 1'b1;
                m_wr_n       = 1'b0;
                m_wstrb_n    = 4'b0000;
                m_addr_n     = i_addr;
                m_wdata_n    = 32'h0;
            end else if (d_req) begin
                state_n      = REQ;
                owner_n      = OWN_DATA;
                m_req_n      = 1'b1;
                m_wr_n       = d_wr;
                m_wstrb_n    = d_wr ? d_wstrb : 4'b0000;
                m_addr_n     = d_addr;
                m_wdata_n    = d_wdata;
                if (i_req) begin
                    starve_cnt_n = starved ? starve_cnt : starve_cnt + CNT_W'(1);
                end else begin
                    starve_cnt_n = '0;
                end
            end else begin
                state_n = IDLE;
                m_req_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            starve_cnt <= '0;
            m_req      <= 1'b0;
            m_wr       <= 1'b0;
            m_wstrb    <= 4'b0000;
            m_addr     <= 32'h0;
            m_wdata    <= 32'h0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            starve_cnt <= starve_cnt_n;
            m_req      <= m_req_n;
            m_wr       <= m_wr_n;
            m_wstrb    <= m_wstrb_n;
            m_addr     <= m_addr_n;
            m_wdata    <= m_wdata_n;
        end
    end

endmodule
